// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and types shared by the fetch unit and the decode stage.
//   PC_STEP          - byte increment between sequential instruction words
//   FETCH_BUF_DEPTH  - depth of the fetch output buffer
//   RESET_PC_DEFAULT - default first fetch address after reset
//   fetch_entry_t    - {instr, pc} record handed from fetch to decode
//   pc_wrap_next     - sequential next pc, wrapping at the end of instruction memory
package fetch_pkg;

  localparam int unsigned PC_STEP          = 4;
  localparam int unsigned FETCH_BUF_DEPTH  = 2;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // limit is the memory size in bytes; the address equal to it wraps to zero.
  function automatic logic [31:0] pc_wrap_next(input logic [31:0] pc,
                                               input logic [31:0] limit);
    logic [31:0] nxt;
    nxt = pc + 32'(PC_STEP);
    return (nxt == limit) ? 32'h0 : nxt;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: two-entry FIFO between instruction memory and decode.
// The head entry is held in a register so the outputs are glitch-free.
//   clk, reset     - clock, synchronous active-high reset
//   push_i         - write push_entry_i at the tail
//   push_entry_i   - {instr, pc} to store
//   pop_i          - head consumed this cycle
//   flush_i        - discard all entries (push/pop ignored)
//   count_o        - occupancy 0..2
//   head_o         - oldest entry (meaningful when count_o != 0)
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  localparam logic [1:0] FULL = 2'(FETCH_BUF_DEPTH);

  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = push_entry_i;
          else                 slot1_d = push_entry_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever remains.
          if (count_q == FULL) begin
            slot0_d = slot1_q;
            slot1_d = push_entry_i;
          end else begin
            slot0_d = push_entry_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = slot0_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with redirect support.
// Issues one address per cycle to a one-cycle-latency instruction memory
// and buffers returning words in a two-entry FIFO toward decode.
//   clk, reset      - clock, synchronous active-high reset
//   imem_addr       - byte address to instruction memory (= pc)
//   imem_instr      - memory data, valid one cycle after the address
//   redirect_valid  - one-cycle branch/jump redirect request
//   redirect_pc     - redirect target byte address
//   out_valid       - out_instr/out_pc hold a fetched instruction
//   out_ready       - decode accepts the instruction
//   out_instr       - fetched instruction word
//   out_pc          - byte address of out_instr
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_SIZE = 128
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_SIZE * PC_STEP);

  logic [31:0]  pc_q, pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         pop;
  logic         issue;
  logic [2:0]   occupancy;
  logic [31:0]  redirect_target;

  assign pop = out_valid && out_ready;

  // Slots committed after this cycle: buffered + returning - leaving.
  // Issuing only while this is below 2 means a push never finds the buffer full.
  assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (occupancy < 3'd2) && !redirect_valid;

  assign redirect_target = (redirect_pc & ~32'h3) % PC_LIMIT;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (issue) begin
      pc_d          = pc_wrap_next(pc_q, PC_LIMIT);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign imem_addr = pc_q;

  assign push_entry.instr = imem_instr;
  assign push_entry.pc    = inflight_pc_q;

  // A redirect flushes the buffer and drops the word returning this cycle,
  // which belongs to the abandoned path.
  fetch_skid_buffer u_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q && !redirect_valid),
    .push_entry_i(push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .count_o     (count),
    .head_o      (head)
  );

  assign out_valid = (count != 2'd0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;

  logic [31:0] imem_addr4, imem_instr4;
  logic        out_valid4;
  logic [31:0] out_instr4, out_pc4;
  logic        rv4_zero = 1'b0;
  logic [31:0] rpc4_zero = 32'h0;
  logic        rdy4_one = 1'b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_SIZE(128)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  fetch_unit #(.RESET_PC(32'h0), .IMEM_SIZE(4)) dut4 (
    .clk(clk), .reset(reset), .imem_addr(imem_addr4), .imem_instr(imem_instr4),
    .redirect_valid(rv4_zero), .redirect_pc(rpc4_zero),
    .out_valid(out_valid4), .out_ready(rdy4_one),
    .out_instr(out_instr4), .out_pc(out_pc4)
  );

  // Instruction memories: word[i] = i, one-cycle read latency.
  always @(posedge clk) begin
    imem_instr  <= imem_addr >> 2;
    imem_instr4 <= imem_addr4 >> 2;
  end

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc,
                              input logic [31:0] einstr, input logic [31:0] eaddr);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev;
    v.epc = epc; v.einstr = einstr; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // cycle 0 is the first cycle with reset low
    tbl[0]  = mk(1, 0, 32'h0,   0, 32'h0,   32'h0,  32'h0);
    tbl[1]  = mk(1, 0, 32'h0,   0, 32'h0,   32'h0,  32'h4);
    tbl[2]  = mk(1, 0, 32'h0,   1, 32'h0,   32'h0,  32'h8);
    tbl[3]  = mk(1, 0, 32'h0,   1, 32'h4,   32'h1,  32'hC);
    tbl[4]  = mk(1, 0, 32'h0,   1, 32'h8,   32'h2,  32'h10);
    tbl[5]  = mk(0, 0, 32'h0,   1, 32'hC,   32'h3,  32'h14);
    tbl[6]  = mk(0, 0, 32'h0,   1, 32'hC,   32'h3,  32'h14);
    tbl[7]  = mk(0, 0, 32'h0,   1, 32'hC,   32'h3,  32'h14);
    tbl[8]  = mk(0, 0, 32'h0,   1, 32'hC,   32'h3,  32'h14);
    tbl[9]  = mk(0, 0, 32'h0,   1, 32'hC,   32'h3,  32'h14);
    tbl[10] = mk(1, 0, 32'h0,   1, 32'hC,   32'h3,  32'h14);
    tbl[11] = mk(1, 0, 32'h0,   1, 32'h10,  32'h4,  32'h18);
    tbl[12] = mk(1, 0, 32'h0,   1, 32'h14,  32'h5,  32'h1C);
    tbl[13] = mk(1, 1, 32'h40,  1, 32'h18,  32'h6,  32'h20);
    tbl[14] = mk(1, 0, 32'h0,   0, 32'h0,   32'h0,  32'h40);
    tbl[15] = mk(1, 0, 32'h0,   0, 32'h0,   32'h0,  32'h44);
    tbl[16] = mk(1, 0, 32'h0,   1, 32'h40,  32'h10, 32'h48);
    tbl[17] = mk(1, 1, 32'h13,  1, 32'h44,  32'h11, 32'h4C);
    tbl[18] = mk(1, 0, 32'h0,   0, 32'h0,   32'h0,  32'h10);
    tbl[19] = mk(1, 0, 32'h0,   0, 32'h0,   32'h0,  32'h14);
    tbl[20] = mk(1, 0, 32'h0,   1, 32'h10,  32'h4,  32'h18);
    tbl[21] = mk(1, 0, 32'h0,   1, 32'h14,  32'h5,  32'h1C);
    tbl[22] = mk(1, 1, 32'h80,  1, 32'h18,  32'h6,  32'h20);
    tbl[23] = mk(1, 1, 32'h100, 0, 32'h0,   32'h0,  32'h80);
    tbl[24] = mk(1, 0, 32'h0,   0, 32'h0,   32'h0,  32'h100);
    tbl[25] = mk(1, 0, 32'h0,   0, 32'h0,   32'h0,  32'h104);
    tbl[26] = mk(1, 0, 32'h0,   1, 32'h100, 32'h40, 32'h108);
    tbl[27] = mk(1, 1, 32'h204, 1, 32'h104, 32'h41, 32'h10C);
    tbl[28] = mk(1, 0, 32'h0,   0, 32'h0,   32'h0,  32'h4);
    tbl[29] = mk(1, 0, 32'h0,   0, 32'h0,   32'h0,  32'h8);
    tbl[30] = mk(1, 0, 32'h0,   1, 32'h4,   32'h1,  32'hC);
    tbl[31] = mk(1, 0, 32'h0,   1, 32'h8,   32'h2,  32'h10);

    reset = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    step();
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    // Reset must win over a simultaneous redirect.
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    chk("rst_prio_addr", imem_addr, 32'h0);
    chk("rst_prio_valid", {31'h0, out_valid}, 32'h0);

    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      out_ready = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc;
      chk($sformatf("v%0d_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].ev});
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].eaddr);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("v%0d_instr", i), out_instr, tbl[i].einstr);
      end
      // Small memory free-runs from the same reset release and wraps every 4 words.
      chk($sformatf("w%0d_valid", i), {31'h0, out_valid4}, (i >= 2) ? 32'h1 : 32'h0);
      if (i >= 2) begin
        chk($sformatf("w%0d_pc", i), out_pc4, 32'(((i - 2) * 4) % 16));
        chk($sformatf("w%0d_instr", i), out_instr4, 32'((i - 2) % 4));
      end
      if (imem_addr4 > 32'hC) chk($sformatf("w%0d_addr_range", i), imem_addr4, 32'hC);
      step();
    end

    // Stall, then reset in the middle of the stall.
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    chk("stall_pc0", out_pc, 32'hC);
    step();
    chk("stall_pc1", out_pc, 32'hC);
    step();
    chk("stall_pc2", out_pc, 32'hC);
    chk("stall_addr", imem_addr, 32'h14);
    reset = 1'b1;
    step();
    chk("midrst_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_pc", out_pc, 32'h0);
    chk("midrst_instr", out_instr, 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    chk("restart_valid1", {31'h0, out_valid}, 32'h0);
    step();
    chk("restart_valid2", {31'h0, out_valid}, 32'h1);
    chk("restart_pc2", out_pc, 32'h0);
    chk("restart_instr2", out_instr, 32'h0);
    step();
    chk("restart_pc3", out_pc, 32'h4);
    chk("restart_instr3", out_instr, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
